load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage directly downstream of the ALU. Takes the ALU's effective address
//  and alignment flags, plus store data and funct3, then runs one bus transaction on a
//  valid/ready request + valid response port. Returns sign/zero-extended load data.
//  Holds the core (busy) until the access completes, times out, or traps.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles allowed in REQ+RSP before bus_err is flagged; 0 disables the timeout
// PORTS
//  clk            in   1   core clock
//  rst_n          in   1   asynchronous, active-low reset
//  req_valid      in   1   core presents a memory op; held stable until done
//  req_read       in   1   load
//  req_write      in   1   store (wins if both read and write are set)
//  req_f3         in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr       in   32  effective address (ALU result)
//  req_aligned    in   aligned_addr_signal  word/halfword alignment flags from ALU
//  req_wdata      in   32  store data, value in LSBs
//  busy           out  1   stall request to core
//  done           out  1   one-cycle completion pulse
//  load_data      out  32  extended load result; valid while done=1
//  misaligned_exc out  1   valid while done=1 (LSU_MISALIGN_TRAP_EN only; else tied 0)
//  bus_err        out  1   timeout flag; valid while done=1
//  mem_req_valid  out  1   bus request valid
//  mem_req_ready  in   1   bus accepts request
//  mem_addr       out  32  word address {req_addr[31:2],2'b00}
//  mem_we         out  1   write enable
//  mem_wstrb      out  4   byte strobes
//  mem_wdata      out  32  lane-replicated store data
//  mem_rsp_valid  in   1   read data / write ack (one cycle)
//  mem_rdata      in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; timeout counter 0. Reset mid-transaction drops
//   mem_req_valid at once; no response is awaited afterwards.
//  FSM:
//   IDLE: accept when req_valid & (read|write).
//     If the access traps: go to DONE.
//     Otherwise: register addr, strobes, wdata, we, f3; go to REQ.
//   REQ: mem_req_valid=1; outputs stay stable until mem_req_ready -> RSP.
//   RSP: wait for mem_rsp_valid -> DONE. Capture the extended mem_rdata (stores: load_data=0).
//   DONE: done=1 for exactly one cycle -> IDLE. A request is never accepted in DONE.
//     Back-to-back ops therefore cost one idle cycle.
//  busy = (state inside {REQ,RSP}) | (IDLE & req_valid & (read|write)). busy=0 in DONE.
//  Latency: zero-wait bus gives done 3 cycles after acceptance (REQ, RSP, DONE).
//  mem_rsp_valid during REQ must not be treated as a response; bus protocol forbids it.
//  Strobes:
//   SB = 4'b0001<<addr[1:0]
//   SH = 4'b0011<<{addr[1],1'b0}
//   SW = 4'b1111
//  wdata: SB replicates byte x4; SH replicates half x2.
//  Load lane select:
//   byte = rdata >> {addr[1:0],3'b0}
//   half = rdata >> {addr[1],4'b0}
//   Then sign-extend (B/H) or zero-extend (BU/HU).
//  Unlisted f3 (011, 110, 111) are treated as W.
//  Timeout: counter runs in REQ/RSP and clears on leaving.
//   At count == TIMEOUT_CYCLES-1 with no progress: go to DONE with bus_err=1, load_data=0.
//   If progress arrives in that same cycle, progress wins and bus_err=0.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   H/HU without halfword_aligned, or W without word_aligned -> IDLE->DONE, misaligned_exc=1.
//   No bus transaction is issued.
//  Undefined: misaligned_exc tied 0; the low address bits are cleared to natural alignment.
//   (H: addr[0]=0; W: addr[1:0]=0.) The access then proceeds normally.
// STRUCTURE
//  holy_core_pkg gains:
//   lsu_state_t {LSU_IDLE, LSU_REQ, LSU_RSP, LSU_DONE}
//   funct3 constants F3_BYTE/F3_HALF/F3_WORD/F3_BYTE_U/F3_HALF_U
//  aligned_addr_signal is reused as-is.
//  Sub-module lsu_lane_align: combinational strobe/wdata replication plus load extract/extend.
//  Shared by the store and load paths.
// TESTING
//  1. SW addr 0x100, wdata 0xDEADBEEF, ready=1, rsp next cycle:
//     mem_addr=0x100, wstrb=1111, done at +3 cycles.
//  2. SB addr 0x103, wdata 0x000000A5: wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
//  3. rdata=0x80FF7F01:
//     LB @0x101 -> 0x0000007F; LB @0x103 -> 0xFFFFFF80; LHU @0x102 -> 0x000080FF.
//  4. LW @0x102:
//     trap build -> done after 1 cycle, misaligned_exc=1, mem_req_valid never 1.
//     Non-trap build -> mem_addr=0x100.
//  5. TIMEOUT_CYCLES=4, mem_req_ready=0: done with bus_err=1 after 4 REQ cycles; load_data=0.
//  6. Assert rst_n=0 during RSP: all outputs 0 asynchronously; the next request completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings, ALU alignment flags
// and the access-size decode used by both the top and the lane aligner.
package load_store_unit_pkg;

    typedef struct packed {
        logic word_aligned;
        logic halfword_aligned;
    } aligned_addr_signal;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RSP  = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        LSU_SZ_BYTE = 2'd0,
        LSU_SZ_HALF = 2'd1,
        LSU_SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    // Encodings outside B/H/BU/HU fall back to a full word access.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_BYTE, F3_BYTE_U: f3_size = LSU_SZ_BYTE;
            F3_HALF, F3_HALF_U: f3_size = LSU_SZ_HALF;
            default:            f3_size = LSU_SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BYTE_U) || (f3 == F3_HALF_U);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: valid/ready request channel plus a single-cycle valid response.
// master = load/store unit, slave = memory.
interface load_store_unit_if;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane logic shared by both directions: store strobes and data replication,
// and load lane extraction with sign/zero extension.
module load_store_unit_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  f3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] byte_sh_s;
    logic [31:0] half_sh_s;
    logic        sext_s;

    // Lane steering for the decoded access size
    always_comb begin
        byte_sh_s = rdata_i >> {addr_lo_i, 3'b000};
        half_sh_s = rdata_i >> {addr_lo_i[1], 4'b0000};
        sext_s    = ~f3_unsigned(f3_i);
        wstrb_o   = 4'b0000;
        wdata_o   = 32'h0000_0000;
        rdata_o   = 32'h0000_0000;
        case (f3_size(f3_i))
            LSU_SZ_BYTE: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext_s & byte_sh_s[7]}}, byte_sh_s[7:0]};
            end
            LSU_SZ_HALF: begin
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext_s & half_sh_s[15]}}, half_sh_s[15:0]};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory transaction per core request, stalling the core until done.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of being force-aligned.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid_i,
    input  logic               req_read_i,
    input  logic               req_write_i,
    input  logic [2:0]         req_f3_i,
    input  logic [31:0]        req_addr_i,
    input  aligned_addr_signal req_aligned_i,
    input  logic [31:0]        req_wdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [31:0]        load_data_o,
    output logic               misaligned_exc_o,
    output logic               bus_err_o,
    load_store_unit_if.master  mem
);

    localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, wdata_q, load_data_q;
    logic [3:0]       wstrb_q;
    logic [2:0]       f3_q;
    logic             we_q, bus_err_q, misaligned_q;

    logic             start_s, trap_s, timeout_s;
    logic [31:0]      addr_fix_s;
    logic [2:0]       lane_f3_s;
    logic [1:0]       lane_addr_s;
    logic [3:0]       lane_wstrb_s;
    logic [31:0]      lane_wdata_s, lane_rdata_s;

    // Request qualification and alignment handling
    always_comb begin
        start_s    = req_valid_i & (req_read_i | req_write_i);
        trap_s     = 1'b0;
        addr_fix_s = req_addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
        case (f3_size(req_f3_i))
            LSU_SZ_HALF: trap_s = ~req_aligned_i.halfword_aligned;
            LSU_SZ_WORD: trap_s = ~req_aligned_i.word_aligned;
            default:     trap_s = 1'b0;
        endcase
`else
        case (f3_size(req_f3_i))
            LSU_SZ_HALF: addr_fix_s = {req_addr_i[31:1], 1'b0};
            LSU_SZ_WORD: addr_fix_s = {req_addr_i[31:2], 2'b00};
            default:     addr_fix_s = req_addr_i;
        endcase
`endif
    end

`ifndef LSU_MISALIGN_TRAP_EN
    logic unused_aligned_s;
    assign unused_aligned_s = ^req_aligned_i;
`endif

    // One aligner serves the store path while idle and the load path once the access is registered
    always_comb begin
        if (state_q == LSU_IDLE) begin
            lane_f3_s   = req_f3_i;
            lane_addr_s = addr_fix_s[1:0];
        end else begin
            lane_f3_s   = f3_q;
            lane_addr_s = addr_q[1:0];
        end
    end

    load_store_unit_lane_align u_lane_align (
        .f3_i      (lane_f3_s),
        .addr_lo_i (lane_addr_s),
        .wdata_i   (req_wdata_i),
        .rdata_i   (mem.mem_rdata),
        .wstrb_o   (lane_wstrb_s),
        .wdata_o   (lane_wdata_s),
        .rdata_o   (lane_rdata_s)
    );

    // State and timeout counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; a handshake or response in the last budget cycle beats the timeout
    always_comb begin
        state_d   = state_q;
        timeout_s = TIMEOUT_EN && (cnt_q == CNT_LAST);
        case (state_q)
            LSU_IDLE: begin
                if (start_s) state_d = trap_s ? LSU_DONE : LSU_REQ;
                else         state_d = LSU_IDLE;
            end
            LSU_REQ: begin
                if (mem.mem_req_ready) state_d = LSU_RSP;
                else if (timeout_s)    state_d = LSU_DONE;
                else                   state_d = LSU_REQ;
            end
            LSU_RSP: begin
                if (mem.mem_rsp_valid || timeout_s) state_d = LSU_DONE;
                else                                state_d = LSU_RSP;
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
        // The budget spans REQ and RSP together, so the count carries across the handshake
        if ((state_q inside {LSU_REQ, LSU_RSP}) && (state_d inside {LSU_REQ, LSU_RSP})) begin
            cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    // Control outputs decoded from the registered state
    always_comb begin
        busy_o            = rst_n & ((state_q == LSU_REQ) | (state_q == LSU_RSP) |
                                     ((state_q == LSU_IDLE) & start_s));
        done_o            = (state_q == LSU_DONE);
        mem.mem_req_valid = (state_q == LSU_REQ);
    end

    // Access registers and completion status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            wstrb_q      <= 4'b0000;
            f3_q         <= 3'b000;
            we_q         <= 1'b0;
            load_data_q  <= 32'h0000_0000;
            bus_err_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (start_s) begin
                        load_data_q  <= 32'h0000_0000;
                        bus_err_q    <= 1'b0;
                        misaligned_q <= trap_s;
                        if (!trap_s) begin
                            addr_q  <= addr_fix_s;
                            f3_q    <= req_f3_i;
                            we_q    <= req_write_i;
                            wstrb_q <= req_write_i ? lane_wstrb_s : 4'b0000;
                            wdata_q <= req_write_i ? lane_wdata_s : 32'h0000_0000;
                        end
                    end
                end
                LSU_REQ: begin
                    if (!mem.mem_req_ready && timeout_s) bus_err_q <= 1'b1;
                end
                LSU_RSP: begin
                    if (mem.mem_rsp_valid) load_data_q <= we_q ? 32'h0000_0000 : lane_rdata_s;
                    else if (timeout_s)    bus_err_q   <= 1'b1;
                end
                default: begin
                    load_data_q  <= 32'h0000_0000;
                    bus_err_q    <= 1'b0;
                    misaligned_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_addr      = {addr_q[31:2], 2'b00};
    assign mem.mem_we        = we_q;
    assign mem.mem_wstrb     = wstrb_q;
    assign mem.mem_wdata     = wdata_q;
    assign load_data_o       = load_data_q;
    assign bus_err_o         = bus_err_q;
    assign misaligned_exc_o  = misaligned_q;

endmodule
